peripheral_uart_tx_serializer_wb: RTL and testbench

//   UART transmit serializer; sits directly downstream of the WishBone UART TX FIFO.

---
 rtl/peripheral_uart_tx_serializer_wb.sv | 217 +++++++++++++++++++++
 tb/tb_peripheral_uart_tx_serializer_wb.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_uart_tx_serializer_wb.sv
// peripheral_uart_tx_serializer_wb
// UART transmit serializer fed by the WishBone UART TX FIFO. Pops one character
// whenever idle with a non-empty FIFO, then shifts out: start bit, 5..8 data
// bits LSB first, optional parity, 1 / 1.5 / 2 stop bits. Bit timing comes from
// a 16x oversampling enable pulse.
//
// Build option: define PERIPHERAL_UART_TX_PARITY_EN to generate the parity bit
// (lcr[3] PEN, lcr[4] EPS, lcr[5] stick). Without it, lcr[5:3] are ignored and
// the PARITY state encoding is reserved and never entered.
module peripheral_uart_tx_serializer_wb #(
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_COUNTER_W = 5,
    parameter int OVERSAMPLE     = 16
) (
    input  logic                      clk,
    input  logic                      wb_rst_i,
    input  logic                      enable,
    input  logic [7:0]                lcr,
    input  logic [DATA_WIDTH-1:0]     fifo_data,
    input  logic [FIFO_COUNTER_W-1:0] fifo_count,
    output logic                      tx_pop,
    output logic                      stx_pad_o,
    output logic [2:0]                tstate,
    output logic                      tx_busy,
    output logic                      tx_empty
);

    // Tick counter must reach 2*OVERSAMPLE-1 for the longest stop period.
    localparam int TICK_W = $clog2(2 * OVERSAMPLE + 1);
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [TICK_W-1:0] BIT_LAST    = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] STOP15_LAST = TICK_W'(OVERSAMPLE + OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] STOP2_LAST  = TICK_W'(2 * OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t                  state_q,   state_d;
    logic [DATA_WIDTH-1:0]   shift_q,   shift_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [TICK_W-1:0]       tick_q,    tick_d;
    logic                    parity_q,  parity_d;   // running XOR of bits already sent
    logic                    line_q,    line_d;     // FSM-driven line level, before break
    logic                    tx_pop_q,  tx_pop_d;
    logic                    stx_q,     stx_d;

    logic                    bit_end;
    logic [BIT_W-1:0]        last_bit;
    logic [TICK_W-1:0]       stop_last;
    logic                    parity_en;
    logic                    parity_bit;
    logic                    cfg_unused;

    // Last data bit index: word length is 5 + lcr[1:0].
    assign last_bit  = BIT_W'(4) + BIT_W'(lcr[1:0]);

    // One full bit period has elapsed on this enable pulse.
    assign bit_end   = enable && (tick_q == BIT_LAST);

    // Stop length: 1 bit, 1.5 bits for 5-bit words with lcr[2], else 2 bits.
    assign stop_last = !lcr[2]           ? BIT_LAST    :
                       (lcr[1:0] == 2'b00) ? STOP15_LAST : STOP2_LAST;

`ifdef PERIPHERAL_UART_TX_PARITY_EN
    assign parity_en  = lcr[3];
    // Stick parity sends ~EPS; otherwise EPS=1 sends the XOR, EPS=0 its inverse.
    assign parity_bit = lcr[5] ? ~lcr[4] : (lcr[4] ? parity_q : ~parity_q);
    assign cfg_unused = lcr[7];
`else
    assign parity_en  = 1'b0;
    assign parity_bit = 1'b0;
    assign cfg_unused = ^{lcr[7], lcr[5:3], parity_q};
`endif

    // Next-state logic for the frame sequencer; lcr is sampled continuously.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path can leave it unassigned and infer a latch.
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tick_d    = tick_q;
        parity_d  = parity_q;
        line_d    = line_q;
        tx_pop_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                line_d = 1'b1;
                if (tx_pop_q) begin
                    // Pop cycle: FIFO head is valid now, capture it and start the frame.
                    shift_d   = fifo_data;
                    bit_cnt_d = '0;
                    tick_d    = '0;
                    parity_d  = 1'b0;
                    line_d    = 1'b0;
                    state_d   = ST_START;
                end else if (fifo_count != '0) begin
                    tx_pop_d = 1'b1;
                end
            end

            ST_START: begin
                if (enable) begin
                    if (bit_end) begin
                        tick_d    = '0;
                        bit_cnt_d = '0;
                        line_d    = shift_q[0];
                        parity_d  = shift_q[0];
                        state_d   = ST_DATA;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end

            ST_DATA: begin
                if (enable) begin
                    if (bit_end) begin
                        tick_d = '0;
                        // >= keeps the FSM moving even if lcr shrinks the word mid-frame.
                        if (bit_cnt_q >= last_bit) begin
                            if (parity_en) begin
                                line_d  = parity_bit;
                                state_d = ST_PARITY;
                            end else begin
                                line_d  = 1'b1;
                                state_d = ST_STOP;
                            end
                        end else begin
                            shift_d   = shift_q >> 1;
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                            line_d    = shift_q[1];
                            parity_d  = parity_q ^ shift_q[1];
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end

`ifdef PERIPHERAL_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (enable) begin
                    if (bit_end) begin
                        tick_d  = '0;
                        line_d  = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
`endif

            ST_STOP: begin
                line_d = 1'b1;
                if (enable) begin
                    if (tick_q >= stop_last) begin
                        // Back-to-back frames: pop in the single IDLE cycle that follows.
                        tick_d   = '0;
                        state_d  = ST_IDLE;
                        tx_pop_d = (fifo_count != '0);
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end

            default: begin
                // Reserved encodings recover to IDLE with the line high.
                line_d  = 1'b1;
                tick_d  = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Break overrides the line level but leaves the sequencer untouched.
        stx_d = line_d & ~lcr[6];
    end

    // State and registered outputs; async reset aborts any frame in flight.
    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tick_q    <= '0;
            parity_q  <= 1'b0;
            line_q    <= 1'b1;
            tx_pop_q  <= 1'b0;
            stx_q     <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tick_q    <= tick_d;
            parity_q  <= parity_d;
            line_q    <= line_d;
            tx_pop_q  <= tx_pop_d;
            stx_q     <= stx_d;
        end
    end

    assign tx_pop    = tx_pop_q;
    assign stx_pad_o = stx_q;
    assign tstate    = state_q;
    assign tx_busy   = (state_q != ST_IDLE);
    assign tx_empty  = (fifo_count == '0) && (state_q == ST_IDLE);

endmodule

// File: tb/tb_peripheral_uart_tx_serializer_wb.sv
// Directed bench for peripheral_uart_tx_serializer_wb: a small FIFO model feeds
// the DUT, each clock's outputs are logged at the falling edge and compared with
// hand-derived frame timings.
module tb_peripheral_uart_tx_serializer_wb;

    localparam int LOG_N = 512;

    logic       clk = 1'b0;
    logic       wb_rst_i;
    logic       enable;
    logic [7:0] lcr;
    logic [7:0] fifo_data;
    logic [4:0] fifo_count;
    logic       tx_pop;
    logic       stx_pad_o;
    logic [2:0] tstate;
    logic       tx_busy;
    logic       tx_empty;

    int checks = 0;
    int errors = 0;

    logic [7:0] fifo_mem [0:3];
    int         head;

    logic       line_log  [0:LOG_N-1];
    logic [2:0] st_log    [0:LOG_N-1];
    logic       busy_log  [0:LOG_N-1];
    logic       empty_log [0:LOG_N-1];
    int         idx;
    int         pop_n;
    int         pop_at [0:3];

    peripheral_uart_tx_serializer_wb #(
        .DATA_WIDTH    (8),
        .FIFO_COUNTER_W(5),
        .OVERSAMPLE    (16)
    ) dut (
        .clk       (clk),
        .wb_rst_i  (wb_rst_i),
        .enable    (enable),
        .lcr       (lcr),
        .fifo_data (fifo_data),
        .fifo_count(fifo_count),
        .tx_pop    (tx_pop),
        .stx_pad_o (stx_pad_o),
        .tstate    (tstate),
        .tx_busy   (tx_busy),
        .tx_empty  (tx_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_fifo(input logic [7:0] w0, input logic [7:0] w1, input int n);
        fifo_mem[0] = w0;
        fifo_mem[1] = w1;
        fifo_mem[2] = 8'h00;
        fifo_mem[3] = 8'h00;
        head        = 0;
        fifo_data   = w0;
        fifo_count  = 5'(n);
    endtask

    task automatic start_log();
        idx   = 0;
        pop_n = 0;
        for (int i = 0; i < 4; i++) pop_at[i] = -1;
    endtask

    // One clock: sample outputs at the falling edge, then let the FIFO model
    // react to a pop just after the rising edge.
    task automatic step();
        logic pop_now;
        @(negedge clk);
        if (idx < LOG_N) begin
            line_log[idx]  = stx_pad_o;
            st_log[idx]    = tstate;
            busy_log[idx]  = tx_busy;
            empty_log[idx] = tx_empty;
        end
        pop_now = tx_pop;
        if (pop_now) begin
            if (pop_n < 4) pop_at[pop_n] = idx;
            pop_n++;
        end
        idx++;
        @(posedge clk);
        #1;
        if (pop_now && fifo_count != 5'd0) begin
            head       = head + 1;
            fifo_count = fifo_count - 5'd1;
            fifo_data  = fifo_mem[head % 4];
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // bits[0] is the start bit, then data LSB first, then parity if present;
    // each lasts 16 clocks, followed by stop_len clocks of stop.
    task automatic check_frame(input string tag, input int base, input logic [15:0] bits,
                               input int nbits, input int stop_len, input logic after_line);
        int s;
        chk($sformatf("%s_st_start", tag), st_log[base], 3'd1);
        chk($sformatf("%s_st_data", tag), st_log[base + 16], 3'd2);
        for (int b = 0; b < nbits; b++) begin
            s = base + 16 * b;
            chk($sformatf("%s_bit%0d_first", tag, b), line_log[s], bits[b]);
            chk($sformatf("%s_bit%0d_last", tag, b), line_log[s + 15], bits[b]);
        end
        s = base + 16 * nbits;
        chk($sformatf("%s_stop_first", tag), line_log[s], 1'b1);
        chk($sformatf("%s_stop_last", tag), line_log[s + stop_len - 1], 1'b1);
        chk($sformatf("%s_st_stop_last", tag), st_log[s + stop_len - 1], 3'd4);
        chk($sformatf("%s_st_after", tag), st_log[s + stop_len], 3'd0);
        chk($sformatf("%s_line_after", tag), line_log[s + stop_len], after_line);
    endtask

    task automatic do_frame(input string tag, input logic [7:0] lcr_v, input logic [7:0] data,
                            input logic [15:0] bits, input int nbits, input int stop_len);
        lcr = lcr_v;
        start_log();
        load_fifo(data, 8'h00, 1);
        run(200);
        chk($sformatf("%s_pop_count", tag), pop_n, 1);
        chk($sformatf("%s_pop_cycle", tag), pop_at[0], 1);
        check_frame(tag, 2, bits, nbits, stop_len, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        wb_rst_i   = 1'b1;
        enable     = 1'b1;
        lcr        = 8'h03;
        fifo_data  = 8'h00;
        fifo_count = 5'd0;
        head       = 0;
        start_log();

        // Reset values
        @(posedge clk);
        #1;
        chk("rst_stx", stx_pad_o, 1'b1);
        chk("rst_pop", tx_pop, 1'b0);
        chk("rst_tstate", tstate, 3'd0);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_empty", tx_empty, 1'b1);
        @(posedge clk);
        #1;
        wb_rst_i = 1'b0;

        // Empty FIFO: no pop, line idle high
        run(4);
        chk("idle_no_pop", pop_n, 0);
        chk("idle_line", line_log[3], 1'b1);

        // 1) 8N1, 0x55
        lcr = 8'h03;
        start_log();
        load_fifo(8'h55, 8'h00, 1);
        run(200);
        chk("t1_pop_count", pop_n, 1);
        chk("t1_pop_cycle", pop_at[0], 1);
        chk("t1_empty_before", empty_log[0], 1'b0);
        check_frame("t1", 2, {7'b0, 8'h55, 1'b0}, 9, 16, 1'b1);
        chk("t1_busy_start", busy_log[2], 1'b1);
        chk("t1_empty_in_stop", empty_log[161], 1'b0);
        chk("t1_empty_done", empty_log[162], 1'b1);
        chk("t1_busy_done", busy_log[162], 1'b0);

        // 2) Parity variants on 0x07
`ifdef PERIPHERAL_UART_TX_PARITY_EN
        do_frame("t2_even", 8'h1B, 8'h07, {6'b0, 1'b1, 8'h07, 1'b0}, 10, 16);
        do_frame("t2_odd", 8'h0B, 8'h07, {6'b0, 1'b0, 8'h07, 1'b0}, 10, 16);
        do_frame("t2_stick", 8'h3B, 8'h07, {6'b0, 1'b0, 8'h07, 1'b0}, 10, 16);
`else
        do_frame("t2_nopar", 8'h1B, 8'h07, {7'b0, 8'h07, 1'b0}, 9, 16);
`endif

        // 3) Stop lengths: 5-bit with 1.5 stop, 8-bit with 2 stop
        do_frame("t3_5b", 8'h04, 8'h1F, {10'b0, 5'h1F, 1'b0}, 6, 24);
        do_frame("t3_8b", 8'h07, 8'h1F, {7'b0, 8'h1F, 1'b0}, 9, 32);

        // 4) Two queued characters go out back to back
        lcr = 8'h03;
        start_log();
        load_fifo(8'hA5, 8'h3C, 2);
        run(340);
        chk("t4_pop_count", pop_n, 2);
        chk("t4_pop0_cycle", pop_at[0], 1);
        chk("t4_pop1_cycle", pop_at[1], 162);
        check_frame("t4a", 2, {7'b0, 8'hA5, 1'b0}, 9, 16, 1'b1);
        check_frame("t4b", 163, {7'b0, 8'h3C, 1'b0}, 9, 16, 1'b1);

        // 5) Break for 20 clocks in the middle of the data bits of 0x0F
        lcr = 8'h03;
        start_log();
        load_fifo(8'h0F, 8'h00, 1);
        run(50);
        lcr = 8'h43;
        run(20);
        lcr = 8'h03;
        run(130);
        chk("t5_pop_cycle", pop_at[0], 1);
        chk("t5_before_break", line_log[50], 1'b1);
        for (int i = 51; i <= 70; i++) chk($sformatf("t5_break_%0d", i), line_log[i], 1'b0);
        chk("t5_fsm_runs", st_log[60], 3'd2);
        chk("t5_released", line_log[71], 1'b1);
        chk("t5_bit4", line_log[82], 1'b0);
        chk("t5_stop_last", line_log[161], 1'b1);
        chk("t5_st_stop_last", st_log[161], 3'd4);
        chk("t5_st_after", st_log[162], 3'd0);
        chk("t5_line_after", line_log[162], 1'b1);

        // 6) Reset during data bit 3 of 0x55, then a clean restart
        lcr = 8'h03;
        start_log();
        load_fifo(8'h55, 8'h00, 1);
        run(70);
        chk("t6_pre_line", line_log[69], 1'b0);
        chk("t6_pre_state", st_log[69], 3'd2);
        wb_rst_i = 1'b1;
        #1;
        chk("t6_rst_stx", stx_pad_o, 1'b1);
        chk("t6_rst_tstate", tstate, 3'd0);
        chk("t6_rst_pop", tx_pop, 1'b0);
        chk("t6_rst_busy", tx_busy, 1'b0);
        @(posedge clk);
        #1;
        wb_rst_i = 1'b0;
        chk("t6_post_stx", stx_pad_o, 1'b1);
        do_frame("t6_restart", 8'h03, 8'h55, {7'b0, 8'h55, 1'b0}, 9, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
